seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multicycle signed 32-bit divider serving the CPU's div instruction.
- Responder side of the StartDiv / DivStop / DivZero handshake driven by the control unit.
- Result registers feed the DivMultHigh/DivMultLow muxes into the High/Low registers: remainder on hi, quotient on lo.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle, sign fix-up in a final cycle.

Parameters:
- WIDTH, 32, operand and result width; the iteration counter is clog2(WIDTH) bits wide.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  StartDiv; sampled only in IDLE.
- dividend  input  WIDTH  two's-complement dividend (register A); sampled at the start edge only.
- divisor  input  WIDTH  two's-complement divisor (register B); sampled at the start edge only.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high in CALC and FIX.
- div_stop  output  1  DivStop; one-cycle completion pulse.
- div_zero  output  1  DivZero; one-cycle divide-by-zero pulse.

Behaviour:
- Reset (async, any state): state=IDLE; hi, lo, busy, div_stop and div_zero all 0; internal quotient, remainder, counter and sign flags all 0.
- States: IDLE, CALC, FIX.
- IDLE, start=1 sampled at edge N, divisor != 0:
  - Latch |dividend| and |divisor|.
  - Latch q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Clear partial remainder; counter=0; go to CALC.
- IDLE, start=1 sampled at edge N, divisor == 0:
  - div_zero=1 during the cycle after edge N; cleared at edge N+1.
  - Stay in IDLE; hi/lo unchanged; div_stop stays 0.
- CALC, one iteration per edge (edges N+1 .. N+32):
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor magnitude from rem in WIDTH+1 bits.
  - If non-negative: keep the difference and set the quo LSB to 1; otherwise restore rem and set the quo LSB to 0.
  - counter increments; at the 32nd iteration (counter==WIDTH-1) go to FIX.
- FIX, edge N+33:
  - lo = q_neg ? -quo : quo; hi = r_neg ? -rem : rem (two's complement, truncated to WIDTH).
  - div_stop=1; go to IDLE.
  - div_stop is cleared at edge N+34.
- Latency: div_stop is high exactly one cycle, 33 cycles after the start edge. hi/lo are valid in that cycle and held until the next completed division or reset.
- Arithmetic semantics:
  - Truncation toward zero; the remainder takes the sign of the dividend (MIPS div).
  - Invariant: dividend == lo*divisor + hi.
  - Magnitude of 0x80000000 is handled as unsigned 0x80000000 (no overflow in the datapath).
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (quotient wraps, no flag).
- start while busy: ignored; no restart, no effect on the result.
- start held high across completion: a new division begins at the first edge after return to IDLE (edge N+34), with operands sampled at that edge.
- busy is asserted from edge N through edge N+33 (CALC and FIX).
- Never asserted together: div_stop and div_zero.
- No output is combinationally dependent on inputs.

Test Plan:
- Reset, then start with 7 / 2 -> busy rises next cycle; div_stop pulses 1 cycle, 33 cycles after the start edge; lo=0x00000003, hi=0x00000001.
- -7 / 2 (0xFFFFFFF9 / 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001. Then -7 / -2 -> lo=0x00000003, hi=0xFFFFFFFF.
- Prior result lo=3, hi=1, then start with 0x12345678 / 0 -> div_zero high exactly one cycle after the start edge; busy and div_stop stay 0; lo=3, hi=1 retained.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then 0x80000000 / 0x00000001 -> lo=0x80000000, hi=0.
- Start 100 / 7; assert start again at cycle 10 with 1 / 1 -> ignored; result lo=14, hi=2 at cycle 33.
- Start 100 / 7; assert reset at cycle 15 -> hi, lo, busy and div_stop all 0 immediately, no div_stop pulse. After reset release, 9 / 3 -> lo=3, hi=0 after 33 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed divider for the CPU div instruction.
//   Radix-2 restoring division on operand magnitudes, one quotient bit per
//   cycle, followed by a single sign fix-up cycle.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   start      StartDiv; only looked at in IDLE
//   dividend   two's-complement dividend, captured on the start edge
//   divisor    two's-complement divisor, captured on the start edge
//   hi         remainder (sign of dividend), registered
//   lo         quotient (truncated toward zero), registered
//   busy       high while CALC or FIX
//   div_stop   one-cycle completion pulse
//   div_zero   one-cycle divide-by-zero pulse; no division is started
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_stop,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;
  logic             zero_q, zero_d;

  // Shifted partial remainder and trial difference. rem < |divisor| <= 2^(W-1),
  // so the shifted value always fits in WIDTH bits; the extra bit of the
  // trial subtraction is the borrow that decides restore vs. keep.
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;

  always_comb begin
    rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {1'b0, dvs_q};
  end

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    stop_d  = 1'b0;
    zero_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            zero_d = 1'b1;
          end else begin
            // Negating 0x80.. yields 0x80.., which read unsigned is the
            // correct magnitude, so no special case is needed.
            quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d   = divisor[WIDTH-1]  ? -divisor  : divisor;
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end

      FIX: begin
        lo_d    = q_neg_q ? -quo_q : quo_q;
        hi_d    = r_neg_q ? -rem_q : rem_q;
        stop_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      zero_q  <= zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign div_stop = stop_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor  = '0;
  logic [31:0] hi, lo;
  logic        busy, div_stop, div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .hi(hi), .lo(lo), .busy(busy),
    .div_stop(div_stop), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive start with operands for one edge (edge N); returns at the
  // negedge following edge N with start dropped.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // Called at the negedge after edge N; k = number of edges after N
  // until div_stop is seen (returns 99 on timeout).
  task automatic wait_done(output int k);
    k = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (div_stop) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int k;
    launch(v.a, v.b);
    chk({name, " busy"}, 32'(busy), 32'd1);
    wait_done(k);
    chk({name, " latency"}, 32'(k), 32'd33);
    chk({name, " lo"}, lo, v.exp_lo);
    chk({name, " hi"}, hi, v.exp_hi);
    chk({name, " busy_done"}, 32'(busy), 32'd0);
    @(negedge clock);
    chk({name, " stop_pulse"}, 32'(div_stop), 32'd0);
  endtask

  initial begin
    int k;
    int pulses;

    vecs[0] = '{32'd7,        32'd2,        32'h00000003, 32'h00000001};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    vecs[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[5] = '{32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000};
    vecs[6] = '{32'd100,      32'd7,        32'd14,       32'd2};
    vecs[7] = '{32'd0,        32'd5,        32'd0,        32'd0};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
    vecs[9] = '{32'd7,        32'd2,        32'h00000003, 32'h00000001};

    // Reset state
    #2;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst flags", {29'd0, busy, div_stop, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Divide by zero: one-cycle pulse, previous result (3,1) retained
    launch(32'h12345678, 32'd0);
    chk("dz pulse", 32'(div_zero), 32'd1);
    chk("dz busy", 32'(busy), 32'd0);
    chk("dz stop", 32'(div_stop), 32'd0);
    @(negedge clock);
    chk("dz clear", 32'(div_zero), 32'd0);
    chk("dz busy2", 32'(busy), 32'd0);
    chk("dz lo", lo, 32'd3);
    chk("dz hi", hi, 32'd1);

    // start while busy is ignored
    launch(32'd100, 32'd7);
    repeat (9) @(negedge clock);
    dividend = 32'd1;
    divisor  = 32'd1;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    wait_done(k);
    chk("ign latency", 32'(k + 10), 32'd33);
    chk("ign lo", lo, 32'd14);
    chk("ign hi", hi, 32'd2);

    // start held across completion: next division starts at edge N+34
    @(negedge clock);
    dividend = 32'd20;
    divisor  = 32'd4;
    start    = 1'b1;
    @(negedge clock);
    wait_done(k);
    chk("held latency", 32'(k), 32'd33);
    chk("held lo", lo, 32'd5);
    chk("held hi", hi, 32'd0);
    dividend = 32'd21;
    @(negedge clock);
    start = 1'b0;
    chk("held restart busy", 32'(busy), 32'd1);
    wait_done(k);
    chk("held2 latency", 32'(k), 32'd33);
    chk("held2 lo", lo, 32'd5);
    chk("held2 hi", hi, 32'd1);

    // Reset mid-calculation
    launch(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid rst hi", hi, 32'd0);
    chk("mid rst lo", lo, 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst stop", 32'(div_stop), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (div_stop || busy) pulses++;
    end
    chk("post rst idle", 32'(pulses), 32'd0);
    run_vec("after rst", '{32'd9, 32'd3, 32'd3, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
